wb_conbus_rr: RTL and testbench
===============================

Name: wb_conbus_rr

Overview:
- Parametrised successor to the fixed 2-master/8-slave Wishbone shared-bus interconnect.
- Supports N masters and M slaves with a parameter-driven address map.
- Arbitrates with a fair round-robin arbiter instead of fixed priority.
- Adds bus error responses for unmapped addresses and for slaves that do not acknowledge within a cycle limit.
- Sits between the LM32 I/D ports, plus future masters such as DMA, and all SoC peripherals.

Parameters:
- N_MASTERS, 2, number of Wishbone masters (1..8).
- N_SLAVES, 8, number of Wishbone slaves (1..16).
- S_ADDR_W, 4, number of upper address bits decoded.
- S_ADDR_MAP, {4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h0}, flattened N_SLAVES*S_ADDR_W map; slave i uses bits [i*S_ADDR_W +: S_ADDR_W].
- TIMEOUT, 255, cycles of stb without ack before err; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- m_adr_i  in  N_MASTERS*32  master addresses.
- m_dat_i  in  N_MASTERS*32  master write data.
- m_sel_i  in  N_MASTERS*4  byte selects.
- m_we_i  in  N_MASTERS  write enables.
- m_cyc_i  in  N_MASTERS  cycle signals.
- m_stb_i  in  N_MASTERS  strobe signals.
- m_dat_o  out  32  read data, shared by all masters; valid with that master's ack.
- m_ack_o  out  N_MASTERS  per-master ack.
- m_err_o  out  N_MASTERS  per-master bus error.
- s_adr_o  out  32  slave address, shared.
- s_dat_o  out  32  slave write data, shared.
- s_sel_o  out  4  byte selects, shared.
- s_we_o  out  1  write enable, shared.
- s_cyc_o  out  N_SLAVES  per-slave cycle.
- s_stb_o  out  N_SLAVES  per-slave strobe.
- s_dat_i  in  N_SLAVES*32  slave read data.
- s_ack_i  in  N_SLAVES  slave acks.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Arbiter enters IDLE; round-robin pointer = 0; timeout counter = 0.
  - All outputs become 0 on the next edge: m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, m_dat_o.
  - Reset mid-transaction aborts it; no ack or err is issued for it.
- Arbiter FSM:
  - States are IDLE and OWNED(g), with a registered grant index g.
  - IDLE: if any m_cyc_i is high, grant the first requester searching from the pointer upward, with wrap-around; go to OWNED(g) on the next edge. Arbitration latency is 1 cycle.
  - OWNED(g): the grant is held while m_cyc_i[g]=1, including back-to-back strobes and LM32 burst/lock sequences.
  - When m_cyc_i[g]=0, go to IDLE and set pointer = (g+1) mod N_MASTERS. Another master can therefore be granted 2 cycles after release, never the same cycle.
  - Simultaneous requests: the pointer resolves order. Each master is served at most once per rotation.
- Shared signals:
  - In OWNED(g), s_adr_o/s_dat_o/s_sel_o/s_we_o = master g's inputs, combinational.
  - In IDLE they are 0.
- Address decode:
  - Combinational compare of m_adr_i[g][31:32-S_ADDR_W] against each S_ADDR_MAP entry.
  - The lowest matching index wins.
  - s_cyc_o[k] = OWNED & m_cyc_i[g] & match k; s_stb_o[k] likewise with m_stb_i[g]. All other slaves see 0.
- Read/ack path:
  - m_dat_o = s_dat_i of the decoded slave; 0 when there is no match.
  - m_ack_o[g] = s_ack_i[k] of the decoded slave, combinational, with zero added latency.
  - Acks from non-selected slaves are ignored.
- Unmapped address:
  - If no map entry matches while stb is high, m_err_o[g] pulses for exactly 1 cycle, registered (1 cycle after stb is seen).
  - It re-pulses every 2 cycles while stb stays high. No s_cyc_o/s_stb_o is asserted.
- Timeout:
  - A 16-bit counter increments each cycle that OWNED & m_stb_i[g] & no ack.
  - It clears on ack, on stb low, or on a grant change.
  - On reaching TIMEOUT: m_err_o[g] pulses 1 cycle, the counter clears, and the slave strobe is forced low in that err cycle.
  - TIMEOUT=0 disables the counter.
- Invariants:
  - m_ack_o and m_err_o are never both high for the same master.
  - At most one bit of s_cyc_o is high.
  - Non-granted masters never see ack or err.

Test Plan:
- Reset with all requests active, rst=0 for 3 cycles → all outputs 0; first grant on the cycle after rst=1 goes to master 0.
- Master 0 reads 0x20000004 while slave 1 acks with 0xDEADBEEF after 2 cycles → s_cyc_o=8'b00000010, m_dat_o=0xDEADBEEF, and m_ack_o=2'b01 in the same cycle as s_ack_i[1].
- Both masters hold cyc for 4 transactions each → grants alternate 0,1,0,1; no master is granted twice consecutively while the other waits.
- Master 1 accesses 0xF0000000 (unmapped) → no s_cyc_o; m_err_o[1] is high for 1 cycle, 1 cycle after stb.
- With TIMEOUT=8, a slave never acks → m_err_o pulses on the 8th stalled cycle and s_stb_o is low in that cycle.
- rst=0 asserted while master 0 waits on slave 3 → next edge: s_cyc_o=0, no ack/err, pointer=0.

Source files
------------

// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: N masters, M slaves, round-robin arbitration,
// upper-address decode, and bus-error responses for unmapped addresses and
// for slaves that stall past the timeout.
//
// Handshake: a master request is valid while cyc & stb are high and stays
// stable until the cycle in which that master sees ack or err (the "ready");
// the transfer completes in exactly that cycle, and the master may then drop
// stb or present the next request.
module wb_conbus_rr #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES = 8,
    parameter int S_ADDR_W = 4,
    parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDR_MAP =
        {4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int TIMEOUT = 255,
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS*32-1:0]   m_adr_i,
    input  logic [N_MASTERS*32-1:0]   m_dat_i,
    input  logic [N_MASTERS*4-1:0]    m_sel_i,
    input  logic [N_MASTERS-1:0]      m_we_i,
    input  logic [N_MASTERS-1:0]      m_cyc_i,
    input  logic [N_MASTERS-1:0]      m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [N_MASTERS-1:0]      m_ack_o,
    output logic [N_MASTERS-1:0]      m_err_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [N_SLAVES-1:0]       s_cyc_o,
    output logic [N_SLAVES-1:0]       s_stb_o,
    input  logic [N_SLAVES*32-1:0]    s_dat_i,
    input  logic [N_SLAVES-1:0]       s_ack_i,
    output logic                      dbg_owned,
    output logic [GW-1:0]             dbg_grant,
    output logic [GW-1:0]             dbg_ptr
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       cand;
    logic                owned;
    logic [31:0]         g_adr;
    logic [31:0]         g_dat;
    logic [3:0]          g_sel;
    logic                g_we;
    logic                g_cyc;
    logic                g_stb;
    logic [N_MASTERS-1:0] grant_vec;
    logic [N_SLAVES-1:0] hit;
    logic                match;
    logic                sel_ack;
    logic [31:0]         sel_dat;
    logic [15:0]         to_cnt;
    logic                to_hit;
    logic                unm_err_q;

    assign owned     = (state == OWNED);
    assign dbg_owned = owned;
    assign dbg_grant = grant;
    assign dbg_ptr   = ptr;

    // Select the granted master's request signals and its one-hot grant mask.
    always_comb begin
        g_adr     = '0;
        g_dat     = '0;
        g_sel     = '0;
        g_we      = 1'b0;
        g_cyc     = 1'b0;
        g_stb     = 1'b0;
        grant_vec = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant == GW'(i)) begin
                g_adr        = m_adr_i[i*32 +: 32];
                g_dat        = m_dat_i[i*32 +: 32];
                g_sel        = m_sel_i[i*4 +: 4];
                g_we         = m_we_i[i];
                g_cyc        = m_cyc_i[i];
                g_stb        = m_stb_i[i];
                grant_vec[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: first requester at or above the pointer, wrapping.
    always_comb begin
        pick = ptr;
        cand = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = GW'((int'(ptr) + i) % N_MASTERS);
            if (m_cyc_i[cand]) pick = cand;
        end
    end

    // Address decode; the lowest matching map entry wins.
    always_comb begin
        hit     = '0;
        match   = 1'b0;
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (g_adr[31 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]) begin
                hit    = '0;
                hit[k] = 1'b1;
                match  = 1'b1;
            end
        end
        for (int k = 0; k < N_SLAVES; k++) begin
            if (hit[k]) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[k*32 +: 32];
            end
        end
    end

    // Timeout fires on the TIMEOUT-th consecutive stalled strobe cycle.
    assign to_hit = (TIMEOUT != 0) && owned && g_cyc && g_stb && match &&
                    (to_cnt == 16'(TIMEOUT - 1));

    // Shared slave-side signals, strobe routing and master responses.
    always_comb begin
        s_adr_o = owned ? g_adr : '0;
        s_dat_o = owned ? g_dat : '0;
        s_sel_o = owned ? g_sel : '0;
        s_we_o  = owned ? g_we : 1'b0;
        s_cyc_o = (owned && g_cyc) ? hit : '0;
        s_stb_o = (owned && g_cyc && g_stb && !to_hit) ? hit : '0;
        m_dat_o = (owned && match) ? sel_dat : '0;
        m_ack_o = (owned && g_cyc && sel_ack && !to_hit) ? grant_vec : '0;
        m_err_o = (owned && ((unm_err_q && !match) || to_hit)) ? grant_vec : '0;
    end

    // Arbiter FSM: hold the grant while the owner keeps cyc, then advance the pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state <= OWNED;
                        grant <= pick;
                    end
                end
                OWNED: begin
                    if (!g_cyc) begin
                        state <= IDLE;
                        ptr   <= (grant == GW'(N_MASTERS - 1)) ? '0 : grant + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Unmapped-address error: one-cycle pulse, repeating every other cycle while stb holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            unm_err_q <= 1'b0;
        end else begin
            unm_err_q <= owned && g_cyc && g_stb && !match && !unm_err_q;
        end
    end

    // Stall counter: counts mapped strobe cycles without ack, cleared on any progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!owned || !g_stb || sel_ack || to_hit || (TIMEOUT == 0)) begin
            to_cnt <= '0;
        end else if (match) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr (2 masters, 8 slaves, default map, TIMEOUT=8).
module tb_wb_conbus_rr;

  localparam int NM = 2;
  localparam int NS = 8;

  logic            clk;
  logic            rst;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS*32-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic             dbg_owned;
  logic [0:0]       dbg_grant;
  logic [0:0]       dbg_ptr;

  logic             auto_ack;
  logic [NS-1:0]    ack_drv;
  int               n_checks;
  int               n_errors;
  logic [31:0]      exp_q[$];

  wb_conbus_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .dbg_owned(dbg_owned), .dbg_grant(dbg_grant), .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model: either acks every strobe immediately or follows ack_drv
  always_comb s_ack_i = auto_ack ? s_stb_o : ack_drv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_master(input int i, input logic [31:0] adr, input logic [31:0] dat,
                              input logic we, input logic cyc, input logic stb);
    m_adr_i[i*32 +: 32] = adr;
    m_dat_i[i*32 +: 32] = dat;
    m_sel_i[i*4 +: 4]   = 4'hF;
    m_we_i[i]           = we;
    m_cyc_i[i]          = cyc;
    m_stb_i[i]          = stb;
  endtask

  task automatic idle_masters();
    for (int i = 0; i < NM; i++) drive_master(i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt [NM];
    logic [NM-1:0] cur_ack;
    logic [31:0] e;

    n_checks = 0;
    n_errors = 0;
    auto_ack = 1'b0;
    ack_drv  = '0;
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = 32'hD000_0000 | k;

    // 1: reset with both masters requesting, then first grant to master 0
    rst = 1'b0;
    drive_master(0, 32'h2000_0000, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
    drive_master(1, 32'h2000_0000, 32'h2222_2222, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_m_ack", 32'(m_ack_o), 32'h0);
    check("rst_m_err", 32'(m_err_o), 32'h0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_s_dat", s_dat_o, 32'h0);
    check("rst_s_we",  32'(s_we_o), 32'h0);
    check("rst_m_dat", m_dat_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("first_owned", 32'(dbg_owned), 32'h1);
    check("first_grant", 32'(dbg_grant), 32'h0);
    check("first_s_cyc", 32'(s_cyc_o), 32'h0000_0002);
    check("first_s_dat", s_dat_o, 32'h1111_1111);
    idle_masters();

    // 2: master 0 reads slave 1, ack after 2 cycles, stray ack from slave 2 ignored
    do_reset();
    drive_master(0, 32'h2000_0004, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("rd_s_cyc", 32'(s_cyc_o), 32'h0000_0002);
    check("rd_s_stb", 32'(s_stb_o), 32'h0000_0002);
    check("rd_s_adr", s_adr_o, 32'h2000_0004);
    check("rd_s_we",  32'(s_we_o), 32'h0);
    check("rd_no_ack", 32'(m_ack_o), 32'h0);
    ack_drv = 8'b0000_0100;
    #1;
    check("rd_stray_ack", 32'(m_ack_o), 32'h0);
    @(negedge clk);
    ack_drv = 8'b0000_0010;
    s_dat_i[1*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("rd_ack", 32'(m_ack_o), 32'h1);
    check("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    check("rd_no_err", 32'(m_err_o), 32'h0);
    @(negedge clk);
    ack_drv = '0;
    idle_masters();

    // 3: both masters do 4 transactions each, releasing cyc after every ack
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
    end
    cnt[0] = 0;
    cnt[1] = 0;
    drive_master(0, 32'h3000_0000, 32'h0000_00A0, 1'b1, 1'b1, 1'b1);
    drive_master(1, 32'h3000_0010, 32'h0000_00B1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 60 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
      @(negedge clk);
      #1;
      cur_ack = m_ack_o;
      if (cur_ack == 2'b11) check("rr_dual_ack", 32'(cur_ack), 32'h1);
      for (int i = 0; i < NM; i++) begin
        if (cur_ack[i]) begin
          check("rr_s_dat", s_dat_o, (i == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check("rr_order", i, e);
          cnt[i]++;
          m_cyc_i[i] = 1'b0;
          m_stb_i[i] = 1'b0;
        end else if (cnt[i] < 4) begin
          m_cyc_i[i] = 1'b1;
          m_stb_i[i] = 1'b1;
        end
      end
    end
    check("rr_cnt0", cnt[0], 32'd4);
    check("rr_cnt1", cnt[1], 32'd4);
    auto_ack = 1'b0;
    idle_masters();

    // 4: master 1 hits an unmapped address; err one cycle after stb, re-pulses
    do_reset();
    drive_master(1, 32'hF000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("unm_grant", 32'(dbg_grant), 32'h1);
    check("unm_s_cyc", 32'(s_cyc_o), 32'h0);
    check("unm_err_c1", 32'(m_err_o), 32'h0);
    @(negedge clk);
    check("unm_err_c2", 32'(m_err_o), 32'h2);
    check("unm_ack_c2", 32'(m_ack_o), 32'h0);
    check("unm_s_stb", 32'(s_stb_o), 32'h0);
    @(negedge clk);
    check("unm_err_c3", 32'(m_err_o), 32'h0);
    @(negedge clk);
    check("unm_err_c4", 32'(m_err_o), 32'h2);
    idle_masters();
    @(negedge clk);

    // 5: slave 3 never acks; err on the 8th stalled cycle with stb forced low
    do_reset();
    drive_master(0, 32'h4000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("to_err_c%0d", c), 32'(m_err_o), (c == 8) ? 32'h1 : 32'h0);
      check($sformatf("to_stb_c%0d", c), 32'(s_stb_o), (c == 8) ? 32'h0 : 32'h8);
      check($sformatf("to_cyc_c%0d", c), 32'(s_cyc_o), 32'h8);
    end
    idle_masters();
    @(negedge clk);

    // 6: reset while master 0 waits on slave 3 (pointer is 1 after test 5)
    drive_master(0, 32'h4000_0004, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("mid_ptr_before", 32'(dbg_ptr), 32'h1);
    check("mid_s_cyc", 32'(s_cyc_o), 32'h8);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ack_drv = 8'b0000_1000;
    @(negedge clk);
    check("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("mid_rst_ack", 32'(m_ack_o), 32'h0);
    check("mid_rst_err", 32'(m_err_o), 32'h0);
    check("mid_rst_ptr", 32'(dbg_ptr), 32'h0);
    check("mid_rst_owned", 32'(dbg_owned), 32'h0);
    ack_drv = '0;
    idle_masters();
    rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
